// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: ALU op codes it decodes,
// FSM state encoding and a small decode helper.
package muldiv_unit_pkg;

  // alucontrol op codes (same values as the EX-stage ALU decoder)
  localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  function automatic logic is_muldiv_op(input logic [7:0] op);
    return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP) ||
           (op == EXE_DIV_OP)  || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One radix-2 restoring-divide step: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Trial subtraction; the extra MSB is the borrow since rem_i < divisor_i.
  always_comb begin
    shifted = {rem_i, bit_i};
    trial   = shifted - {1'b0, divisor_i};
    qbit_o  = ~trial[WIDTH];
    rem_o   = qbit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit for the EX stage. Produces a {hi,lo}
// result pair; busy stalls the pipeline while an iterative op runs.
// Optional feature macro: MULDIV_FAST_MUL_EN (single-cycle multiply).
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       alucontrol,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t state_q, state_d;

  logic [CNT_W-1:0]   cnt_q;
  logic               op_div_q, neg_q, rsign_q;
  logic [2*WIDTH-1:0] acc_q, mcand_q;
  logic [WIDTH-1:0]   mplier_q, dvsr_q, quot_q, rem_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               is_mul, is_div, is_signed, accept, div_zero, last_iter;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   step_rem;
  logic               step_q;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix, res_hi, res_lo;

  // Magnitude of an operand; signed MIN maps to unsigned 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  // Op decode and acceptance (flush in IDLE drops a coincident start).
  always_comb begin
    is_mul    = 1'b0;
    is_div    = 1'b0;
    is_signed = 1'b0;
    case (alucontrol)
      EXE_MULT_OP:  begin is_mul = 1'b1; is_signed = 1'b1; end
      EXE_MULTU_OP: begin is_mul = 1'b1; end
      EXE_DIV_OP:   begin is_div = 1'b1; is_signed = 1'b1; end
      EXE_DIVU_OP:  begin is_div = 1'b1; end
      default: ;
    endcase
    accept    = start && !flush && (state_q == ST_IDLE) && is_muldiv_op(alucontrol);
    div_zero  = (b == '0);
    mag_a     = magnitude(a, is_signed);
    mag_b     = magnitude(b, is_signed);
    last_iter = (cnt_q == LAST_CNT);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;

  // Single-cycle full-width product, signed or unsigned per op.
  always_comb begin
    if (is_signed)
      fast_prod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    else
      fast_prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  end
`endif

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i     (rem_q),
    .divisor_i (dvsr_q),
    .bit_i     (quot_q[WIDTH-1]),
    .rem_o     (step_rem),
    .qbit_o    (step_q)
  );

  // Sign fix-up of the magnitude result, applied during FIX.
  always_comb begin
    prod_fix = neg_q   ? -acc_q  : acc_q;
    quot_fix = neg_q   ? -quot_q : quot_q;
    rem_fix  = rsign_q ? -rem_q  : rem_q;
    res_hi   = op_div_q ? rem_fix  : prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = op_div_q ? quot_fix : prod_fix[WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and status outputs; hi/lo show the new result in the done cycle.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    hi      = hi_q;
    lo      = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_div)
            state_d = div_zero ? ST_FIX : ST_DIV;
          else
`ifdef MULDIV_FAST_MUL_EN
            state_d = ST_FIX;
`else
            state_d = ST_MUL;
`endif
        end
      end
      ST_MUL, ST_DIV: begin
        busy = 1'b1;
        if (flush)          state_d = ST_IDLE;
        else if (last_iter) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!flush) begin
          done = 1'b1;
          hi   = res_hi;
          lo   = res_lo;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand latch, shift-add / restoring-divide iterations and hi/lo commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      op_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rsign_q  <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      dvsr_q   <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cnt_q    <= '0;
            op_div_q <= is_div;
            neg_q    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            rsign_q  <= is_signed & a[WIDTH-1];
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, mag_a};
            mplier_q <= mag_b;
            dvsr_q   <= mag_b;
            quot_q   <= mag_a;
            rem_q    <= '0;
            // Divide by zero: preload the fixed result with no sign fix-up.
            if (is_div && div_zero) begin
              quot_q  <= '1;
              rem_q   <= a;
              neg_q   <= 1'b0;
              rsign_q <= 1'b0;
            end
`ifdef MULDIV_FAST_MUL_EN
            if (!is_div) begin
              acc_q <= fast_prod;
              neg_q <= 1'b0;
            end
`endif
          end
        end
        ST_MUL: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (!last_iter) cnt_q <= cnt_q + 1'b1;
        end
        ST_DIV: begin
          rem_q  <= step_rem;
          quot_q <= {quot_q[WIDTH-2:0], step_q};
          if (!last_iter) cnt_q <= cnt_q + 1'b1;
        end
        ST_FIX: begin
          if (!flush) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit (WIDTH=32).
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  alucontrol = 8'h00;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_h, last_l;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .alucontrol(alucontrol), .start(start), .flush(flush),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Drive a start for one cycle (called at a negedge; returns in cycle T+1).
  task automatic launch(input logic [7:0] op, input logic [31:0] av, input logic [31:0] bv);
    alucontrol = op; a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for done (bounded); k=1 is the cycle in which measure is entered.
  task automatic measure(input int maxc, output int lat, output int nbusy,
                         output logic bdone, output logic [31:0] h, output logic [31:0] l);
    lat = 0; nbusy = 0; bdone = 1'b0; h = '0; l = '0;
    for (int k = 1; k <= maxc && lat == 0; k++) begin
      if (busy) nbusy++;
      if (done) begin lat = k; bdone = busy; h = hi; l = lo; end
      @(negedge clk);
    end
  endtask

  // Count done pulses over a number of cycles.
  task automatic count_done(input int ncyc, output int nd);
    nd = 0;
    for (int k = 0; k < ncyc; k++) begin
      if (done) nd++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL rst_hi: got %h want 00000000", hi); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL rst_lo: got %h want 00000000", lo); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle: got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_mul();
    int lat, nb; logic bd; logic [31:0] h, l;
    launch(EXE_MULTU_OP, 32'hFFFFFFFF, 32'h00000002);
    measure(60, lat, nb, bd, h, l);
    n_checks++; if (lat !== MUL_LAT) begin n_fail++; $display("FAIL multu_lat: got %0d want %0d", lat, MUL_LAT); end
    n_checks++; if (nb !== MUL_LAT - 1) begin n_fail++; $display("FAIL multu_busy_cycles: got %0d want %0d", nb, MUL_LAT - 1); end
    n_checks++; if (bd !== 1'b0) begin n_fail++; $display("FAIL multu_busy_at_done: got %b want 0", bd); end
    n_checks++; if (h !== 32'h00000001 || l !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_res: got %h_%h want 00000001_FFFFFFFE", h, l); end
    n_checks++; if (hi !== 32'h00000001 || lo !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_hold: got %h_%h want 00000001_FFFFFFFE", hi, lo); end

    launch(EXE_MULT_OP, 32'hFFFFFFFD, 32'h00000007);
    measure(60, lat, nb, bd, h, l);
    n_checks++; if (lat !== MUL_LAT) begin n_fail++; $display("FAIL mult_lat: got %0d want %0d", lat, MUL_LAT); end
    n_checks++; if (h !== 32'hFFFFFFFF || l !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mult_neg: got %h_%h want FFFFFFFF_FFFFFFEB", h, l); end

    launch(EXE_MULTU_OP, 32'hFFFFFFFD, 32'h00000007);
    measure(60, lat, nb, bd, h, l);
    n_checks++; if (h !== 32'h00000006 || l !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL multu_big: got %h_%h want 00000006_FFFFFFEB", h, l); end

    launch(EXE_MULT_OP, 32'h80000000, 32'h80000000);
    measure(60, lat, nb, bd, h, l);
    n_checks++; if (h !== 32'h40000000 || l !== 32'h00000000) begin n_fail++; $display("FAIL mult_min_min: got %h_%h want 40000000_00000000", h, l); end
  endtask

  task automatic test_div();
    int lat, nb; logic bd; logic [31:0] h, l;
    launch(EXE_DIV_OP, 32'hFFFFFFF9, 32'h00000002);
    measure(60, lat, nb, bd, h, l);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL div_lat: got %0d want 33", lat); end
    n_checks++; if (nb !== 32) begin n_fail++; $display("FAIL div_busy_cycles: got %0d want 32", nb); end
    n_checks++; if (h !== 32'hFFFFFFFF || l !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_neg_dividend: got %h_%h want FFFFFFFF_FFFFFFFD", h, l); end

    launch(EXE_DIV_OP, 32'h00000007, 32'hFFFFFFFE);
    measure(60, lat, nb, bd, h, l);
    n_checks++; if (h !== 32'h00000001 || l !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_neg_divisor: got %h_%h want 00000001_FFFFFFFD", h, l); end

    launch(EXE_DIV_OP, 32'h80000000, 32'hFFFFFFFF);
    measure(60, lat, nb, bd, h, l);
    n_checks++; if (h !== 32'h00000000 || l !== 32'h80000000) begin n_fail++; $display("FAIL div_min_m1: got %h_%h want 00000000_80000000", h, l); end

    launch(EXE_DIVU_OP, 32'hFFFFFFFF, 32'h00000010);
    measure(60, lat, nb, bd, h, l);
    n_checks++; if (h !== 32'h0000000F || l !== 32'h0FFFFFFF) begin n_fail++; $display("FAIL divu_big: got %h_%h want 0000000F_0FFFFFFF", h, l); end
  endtask

  task automatic test_div_zero();
    int lat, nb; logic bd; logic [31:0] h, l;
    launch(EXE_DIVU_OP, 32'h00000005, 32'h00000000);
    measure(60, lat, nb, bd, h, l);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL divu0_lat: got %0d want 1", lat); end
    n_checks++; if (nb !== 0) begin n_fail++; $display("FAIL divu0_busy: got %0d want 0", nb); end
    n_checks++; if (h !== 32'h00000005 || l !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divu0_res: got %h_%h want 00000005_FFFFFFFF", h, l); end

    launch(EXE_DIV_OP, 32'hFFFFFFFB, 32'h00000000);
    measure(60, lat, nb, bd, h, l);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL div0_lat: got %0d want 1", lat); end
    n_checks++; if (h !== 32'hFFFFFFFB || l !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div0_res: got %h_%h want FFFFFFFB_FFFFFFFF", h, l); end
    last_h = 32'hFFFFFFFB; last_l = 32'hFFFFFFFF;
  endtask

  task automatic test_flush();
    int lat, nb, nd; logic bd; logic [31:0] h, l;
    // Flush a divide in flight during cycle T+10.
    launch(EXE_DIV_OP, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_before: got %b want 1", busy); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy_after: got %b want 0", busy); end
    count_done(40, nd);
    n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL flush_no_done: got %0d pulses want 0", nd); end
    n_checks++; if (hi !== last_h || lo !== last_l) begin n_fail++; $display("FAIL flush_hold: got %h_%h want %h_%h", hi, lo, last_h, last_l); end

    launch(EXE_DIVU_OP, 32'd100, 32'd7);
    measure(60, lat, nb, bd, h, l);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL divu_after_flush_lat: got %0d want 33", lat); end
    n_checks++; if (h !== 32'h00000002 || l !== 32'h0000000E) begin n_fail++; $display("FAIL divu_after_flush: got %h_%h want 00000002_0000000E", h, l); end
    last_h = 32'h00000002; last_l = 32'h0000000E;

    // Flush in the FIX cycle (T+33) of DIVU 20/3.
    launch(EXE_DIVU_OP, 32'd20, 32'd3);
    repeat (32) @(negedge clk);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL fix_done_seen: got %b want 1", done); end
    flush = 1'b1;
    #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL fix_flush_done: got %b want 0", done); end
    n_checks++; if (hi !== last_h || lo !== last_l) begin n_fail++; $display("FAIL fix_flush_out: got %h_%h want %h_%h", hi, lo, last_h, last_l); end
    @(negedge clk);
    flush = 1'b0;
    count_done(5, nd);
    n_checks++; if (nd !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL fix_flush_after: got done=%0d busy=%b want 0 0", nd, busy); end
    n_checks++; if (hi !== last_h || lo !== last_l) begin n_fail++; $display("FAIL fix_flush_hold: got %h_%h want %h_%h", hi, lo, last_h, last_l); end

    // flush and start in the same IDLE cycle: start dropped.
    alucontrol = EXE_MULTU_OP; a = 32'd3; b = 32'd3; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL flush_start_idle: got busy=%b done=%b want 0 0", busy, done); end
    count_done(40, nd);
    n_checks++; if (nd !== 0 || hi !== last_h || lo !== last_l) begin n_fail++; $display("FAIL flush_start_drop: got done=%0d %h_%h want 0 %h_%h", nd, hi, lo, last_h, last_l); end
  endtask

  task automatic test_reset_midop();
    int nd;
    launch(EXE_DIVU_OP, 32'd60, 32'd7);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL async_rst_ctrl: got busy=%b done=%b want 0 0", busy, done); end
    n_checks++; if (hi !== 32'h0 || lo !== 32'h0) begin n_fail++; $display("FAIL async_rst_data: got %h_%h want 00000000_00000000", hi, lo); end
    @(negedge clk);
    rst = 1'b0;
    count_done(40, nd);
    n_checks++; if (nd !== 0 || hi !== 32'h0) begin n_fail++; $display("FAIL rst_op_lost: got done=%0d hi=%h want 0 00000000", nd, hi); end
    last_h = '0; last_l = '0;
  endtask

  task automatic test_ignored_starts();
    int lat, nb, nd; logic bd; logic [31:0] h, l;
    // Non-muldiv op code.
    launch(EXE_ADD_OP, 32'd5, 32'd6);
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL add_start: got busy=%b done=%b want 0 0", busy, done); end
    count_done(40, nd);
    n_checks++; if (nd !== 0 || hi !== last_h || lo !== last_l) begin n_fail++; $display("FAIL add_ignored: got done=%0d %h_%h want 0 %h_%h", nd, hi, lo, last_h, last_l); end

    // Second start while busy (applied in T+5) must not disturb the first op.
    launch(EXE_DIVU_OP, 32'd60, 32'd7);
    repeat (4) @(negedge clk);
    launch(EXE_DIVU_OP, 32'd9, 32'd3);
    measure(60, lat, nb, bd, h, l);
    n_checks++; if (lat !== 28) begin n_fail++; $display("FAIL busy_start_lat: got %0d want 28", lat); end
    n_checks++; if (h !== 32'h00000004 || l !== 32'h00000008) begin n_fail++; $display("FAIL busy_start_res: got %h_%h want 00000004_00000008", h, l); end
    count_done(40, nd);
    n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL busy_start_extra_done: got %0d want 0", nd); end
  endtask

  initial begin
    last_h = '0; last_l = '0;
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_flush();
    test_reset_midop();
    test_ignored_starts();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
